// File: rtl/draw_pkg.sv
// Shared constants, state encoding and a wrap helper for the draw request arbiter.
package draw_pkg;

    localparam int TYPE_W = 5;
    localparam int X_W    = 9;
    localparam int Y_W    = 8;
    localparam int ID_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAW    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Advance a requester index by one, wrapping to 0 past n-1.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
        if (int'(v) + 1 >= n) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/draw_request_arbiter_rr_select.sv
// Combinational round-robin pick: first set request bit at or above ptr, modulo NUM_REQ.
module rr_select
    import draw_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    // Rotating the request vector right by ptr puts the highest-priority bit at offset 0.
    logic [2*NUM_REQ-1:0] rotated;
    int                   cand;

    assign rotated = {req, req} >> ptr;

    // Scan offsets from the far end down so the lowest offset is the last (winning) write.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (rotated[off]) begin
                cand = int'(ptr) + off;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                valid = 1'b1;
                idx   = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/draw_request_arbiter.sv
// Round-robin arbiter sharing one object-drawing engine between page controllers.
//
// Handshake: a requester raises req_start (with type/x/y stable) and holds it until it
// sees a one-cycle req_done; dropping req_start early aborts the object. The engine sees
// draw_start held high for the whole object and answers with a one-cycle draw_done, which
// is routed back to the granted requester only. draw_start always drops for at least one
// cycle between objects.
module draw_request_arbiter
#(
    parameter int NUM_REQ = 4,
    parameter int TYPE_W  = draw_pkg::TYPE_W,
    parameter int X_W     = draw_pkg::X_W,
    parameter int Y_W     = draw_pkg::Y_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_start,
    input  logic [NUM_REQ*TYPE_W-1:0] req_type,
    input  logic [NUM_REQ*X_W-1:0]    req_x,
    input  logic [NUM_REQ*Y_W-1:0]    req_y,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      draw_start,
    output logic [TYPE_W-1:0]         draw_type,
    output logic [X_W-1:0]            draw_x,
    output logic [Y_W-1:0]            draw_y,
    input  logic                      draw_done,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic [1:0]                fsm_state
);

    import draw_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    grant_q;
    logic [ID_W-1:0]    grant_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;

    logic               sel_valid;
    logic [ID_W-1:0]    sel_idx;

    logic               g_start;
    logic [TYPE_W-1:0]  g_type;
    logic [X_W-1:0]     g_x;
    logic [Y_W-1:0]     g_y;
    logic [NUM_REQ-1:0] g_onehot;

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req   (req_start),
        .ptr   (rr_ptr_q),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // Pick out the granted requester's start bit, command fields and done position.
    always_comb begin
        g_start  = 1'b0;
        g_type   = '0;
        g_x      = '0;
        g_y      = '0;
        g_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_start     = req_start[i];
                g_type      = req_type[i*TYPE_W +: TYPE_W];
                g_x         = req_x[i*X_W +: X_W];
                g_y         = req_y[i*Y_W +: Y_W];
                g_onehot[i] = 1'b1;
            end
        end
    end

    // State, grant and round-robin pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic and engine/requester outputs; done wins over a same-cycle abort.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        draw_start = 1'b0;
        draw_type  = '0;
        draw_x     = '0;
        draw_y     = '0;
        req_done   = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_idx;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                draw_start = 1'b1;
                draw_type  = g_type;
                draw_x     = g_x;
                draw_y     = g_y;
                if (draw_done) begin
                    req_done = g_onehot;
                    rr_ptr_d = wrap_inc(grant_q, NUM_REQ);
                    state_d  = S_RELEASE;
                end else if (!g_start) begin
                    rr_ptr_d = wrap_inc(grant_q, NUM_REQ);
                    state_d  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q == S_DRAW) || (state_q == S_RELEASE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Self-checking bench for draw_request_arbiter: grants are predicted into a queue when
// requests are driven and popped when the arbiter raises draw_start.
module tb_draw_request_arbiter;
  import draw_pkg::*;

  localparam int N  = 4;
  localparam int EW = 3 + TYPE_W + X_W + Y_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_start = '0;
  logic [N*TYPE_W-1:0] req_type = '0;
  logic [N*X_W-1:0]  req_x = '0;
  logic [N*Y_W-1:0]  req_y = '0;
  logic [N-1:0]      req_done;
  logic              draw_start;
  logic [TYPE_W-1:0] draw_type;
  logic [X_W-1:0]    draw_x;
  logic [Y_W-1:0]    draw_y;
  logic              draw_done = 1'b0;
  logic [2:0]        grant_id;
  logic              busy;
  logic [1:0]        fsm_state;

  logic [EW-1:0]     exp_q[$];
  logic [TYPE_W-1:0] slot_t[N];
  logic [X_W-1:0]    slot_x[N];
  logic [Y_W-1:0]    slot_y[N];
  logic [2:0]        cur_id = '0;
  int                n_checks = 0;
  int                n_fail = 0;

  draw_request_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_start  (req_start),
    .req_type   (req_type),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_done   (req_done),
    .draw_start (draw_start),
    .draw_type  (draw_type),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_done  (draw_done),
    .grant_id   (grant_id),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_slot(input int i, input logic [TYPE_W-1:0] t,
                          input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    slot_t[i] = t;
    slot_x[i] = x;
    slot_y[i] = y;
    req_type[i*TYPE_W +: TYPE_W] = t;
    req_x[i*X_W +: X_W] = x;
    req_y[i*Y_W +: Y_W] = y;
  endtask

  task automatic rand_slots();
    for (int i = 0; i < N; i++) begin
      set_slot(i, TYPE_W'($urandom_range(0, 31)), X_W'($urandom_range(0, 511)),
               Y_W'($urandom_range(0, 255)));
    end
  endtask

  task automatic push_exp(input int i);
    exp_q.push_back({3'(i), slot_t[i], slot_x[i], slot_y[i]});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req_start = '0;
    draw_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait for draw_start, then pop and compare the predicted grant and command.
  task automatic wait_grant(output int low);
    logic [EW-1:0] e;
    logic got;
    got = 1'b0;
    low = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (draw_start === 1'b1) begin
        got = 1'b1;
        break;
      end
      low++;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL grant_timeout: draw_start stayed 0 for 32 cycles, required 1");
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL grant_unexpected: got grant_id=%0d, required no grant", grant_id);
    end else begin
      e = exp_q.pop_front();
      cur_id = e[EW-1 -: 3];
      if ({grant_id, draw_type, draw_x, draw_y, busy} !== {e, 1'b1}) begin
        n_fail++;
        $display("FAIL grant_cmd: got id=%0d type=%0d x=%0d y=%0d busy=%b, required id=%0d type=%0d x=%0d y=%0d busy=1",
                 grant_id, draw_type, draw_x, draw_y, busy, e[EW-1 -: 3],
                 e[X_W+Y_W +: TYPE_W], e[Y_W +: X_W], e[Y_W-1:0]);
      end
    end
  endtask

  // Engine model: hold for lat cycles, pulse draw_done, then check the release cycle.
  task automatic finish_draw(input int lat, input logic drop);
    repeat (lat - 1) begin
      @(negedge clk);
      n_checks++;
      if (draw_start !== 1'b1 || req_done !== '0) begin
        n_fail++;
        $display("FAIL draw_hold: got start=%b done=%b, required start=1 done=0000", draw_start, req_done);
      end
    end
    @(negedge clk);
    draw_done = 1'b1;
    #1;
    n_checks++;
    if (req_done !== (4'(1) << cur_id)) begin
      n_fail++;
      $display("FAIL done_route: got req_done=%b, required %b", req_done, 4'(1) << cur_id);
    end
    @(negedge clk);
    draw_done = 1'b0;
    if (drop) req_start[cur_id] = 1'b0;
    #1;
    n_checks++;
    if ({draw_start, req_done, draw_type, draw_x, draw_y, fsm_state} !==
        {1'b0, 4'b0, {TYPE_W{1'b0}}, {X_W{1'b0}}, {Y_W{1'b0}}, S_RELEASE}) begin
      n_fail++;
      $display("FAIL release_cycle: got start=%b done=%b type=%0d x=%0d y=%0d state=%0d, required 0/0000/0/0/0/%0d",
               draw_start, req_done, draw_type, draw_x, draw_y, fsm_state, S_RELEASE);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({draw_start, req_done, draw_type, draw_x, draw_y, grant_id, busy, fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got start=%b done=%b type=%0d x=%0d y=%0d id=%0d busy=%b state=%0d, required all 0",
               draw_start, req_done, draw_type, draw_x, draw_y, grant_id, busy, fsm_state);
    end
  endtask

  task automatic test_single();
    int low;
    @(negedge clk);
    rand_slots();
    set_slot(1, 5'd31, 9'd98, 8'd97);
    req_start = 4'b0010;
    push_exp(1);
    wait_grant(low);
    n_checks++;
    if (low !== 0) begin
      n_fail++;
      $display("FAIL single_latency: got %0d idle cycles before draw_start, required 0", low);
    end
    finish_draw(3, 1'b1);
    @(negedge clk);
    n_checks++;
    if (draw_start !== 1'b0 || fsm_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL single_gap: got start=%b state=%0d, required start=0 state=%0d", draw_start, fsm_state, S_IDLE);
    end
  endtask

  task automatic test_contention();
    int low;
    apply_reset();
    rand_slots();
    req_start = 4'b1111;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    for (int g = 0; g < 5; g++) begin
      wait_grant(low);
      // the release cycle was consumed by finish_draw, so the low gap is low + 1
      if (g > 0) begin
        n_checks++;
        if (low + 1 !== 2) begin
          n_fail++;
          $display("FAIL contention_gap: got %0d low cycles between objects, required 2", low + 1);
        end
      end
      finish_draw(5, 1'b0);
    end
    req_start = '0;
  endtask

  task automatic test_back_to_back();
    int low;
    @(negedge clk);
    req_start = 4'b1000;
    push_exp(3);
    wait_grant(low);
    finish_draw(2, 1'b1);
    @(negedge clk);
    req_start = 4'b1001;
    push_exp(0);
    push_exp(3);
    wait_grant(low);
    finish_draw(2, 1'b1);
    wait_grant(low);
    n_checks++;
    if (low !== 1) begin
      n_fail++;
      $display("FAIL wrap_gap: got %0d idle cycles, required 1", low);
    end
    finish_draw(2, 1'b1);
  endtask

  task automatic test_abort();
    int low;
    @(negedge clk);
    req_start = 4'b0100;
    push_exp(2);
    wait_grant(low);
    @(negedge clk);
    req_start[2] = 1'b0;
    #1;
    n_checks++;
    if (draw_start !== 1'b1 || req_done !== '0) begin
      n_fail++;
      $display("FAIL abort_draw: got start=%b done=%b, required start=1 done=0000", draw_start, req_done);
    end
    @(negedge clk);
    draw_done = 1'b1;
    #1;
    n_checks++;
    if (fsm_state !== S_RELEASE || draw_start !== 1'b0 || req_done !== '0) begin
      n_fail++;
      $display("FAIL abort_release: got state=%0d start=%b done=%b, required state=%0d start=0 done=0000",
               fsm_state, draw_start, req_done, S_RELEASE);
    end
    @(negedge clk);
    draw_done = 1'b0;
    #1;
    n_checks++;
    if (fsm_state !== S_IDLE || busy !== 1'b0 || req_done !== '0) begin
      n_fail++;
      $display("FAIL abort_idle: got state=%0d busy=%b done=%b, required state=%0d busy=0 done=0000",
               fsm_state, busy, req_done, S_IDLE);
    end
    // pointer moved past 2, so 3 wins before 0
    req_start = 4'b1001;
    push_exp(3);
    push_exp(0);
    wait_grant(low);
    finish_draw(2, 1'b1);
    wait_grant(low);
    finish_draw(2, 1'b1);
  endtask

  task automatic test_simultaneous();
    int low;
    @(negedge clk);
    req_start = 4'b0010;
    push_exp(1);
    wait_grant(low);
    @(negedge clk);
    draw_done = 1'b1;
    req_start[1] = 1'b0;
    #1;
    n_checks++;
    if (req_done !== 4'b0010) begin
      n_fail++;
      $display("FAIL simultaneous_done: got req_done=%b, required 0010", req_done);
    end
    @(negedge clk);
    draw_done = 1'b0;
    #1;
    n_checks++;
    if (fsm_state !== S_RELEASE || req_done !== '0) begin
      n_fail++;
      $display("FAIL simultaneous_release: got state=%0d done=%b, required state=%0d done=0000",
               fsm_state, req_done, S_RELEASE);
    end
  endtask

  task automatic test_reset_mid_draw();
    int low;
    @(negedge clk);
    req_start = 4'b0100;
    push_exp(2);
    wait_grant(low);
    @(negedge clk);
    n_checks++;
    if (draw_start !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_draw_active: got start=%b, required 1", draw_start);
    end
    reset = 1'b1;
    req_start = '0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({draw_start, req_done, draw_type, draw_x, draw_y, grant_id, busy, fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL mid_draw_reset: got start=%b done=%b type=%0d x=%0d y=%0d id=%0d busy=%b state=%0d, required all 0",
               draw_start, req_done, draw_type, draw_x, draw_y, grant_id, busy, fsm_state);
    end
    reset = 1'b0;
    rand_slots();
    req_start = 4'b1010;
    push_exp(1);
    push_exp(3);
    wait_grant(low);
    finish_draw(2, 1'b1);
    wait_grant(low);
    finish_draw(2, 1'b1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_abort();
    test_simultaneous();
    test_reset_mid_draw();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d grants still expected, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_request_arbiter.md
Name: draw_request_arbiter

Overview:
- Shares the single object-drawing engine between several page/screen controllers: win page, lose page, score overlay and game field.
- Each requester holds start high with its object type and x/y position until it receives a done pulse.
- The arbiter grants one requester at a time in round-robin order, forwards the winner's command to the engine, and routes the engine's done pulse back to the winner only.
- It sits between the page controllers and the drawer, inside the top-level VGA drawing path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TYPE_W, 5, object-type field width.
- X_W, 9, x-coordinate width.
- Y_W, 8, y-coordinate width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_start  in  NUM_REQ  per-requester draw request; level, held until that requester's done.
- req_type  in  NUM_REQ*TYPE_W  packed object types; requester i occupies bits [i*TYPE_W +: TYPE_W].
- req_x  in  NUM_REQ*X_W  packed x positions, same packing.
- req_y  in  NUM_REQ*Y_W  packed y positions, same packing.
- req_done  out  NUM_REQ  one-hot, one-cycle done pulse to the granted requester.
- draw_start  out  1  start to the drawing engine.
- draw_type  out  TYPE_W  object type to the engine.
- draw_x  out  X_W  x position to the engine.
- draw_y  out  Y_W  y position to the engine.
- draw_done  in  1  one-cycle done pulse from the engine.
- grant_id  out  3  index of the current or last grant.
- busy  out  1  high in S_DRAW and S_RELEASE.

Behaviour:
- Reset (synchronous, active-high, any state): state=S_IDLE, grant_id=0, rr_ptr=0, all outputs 0. This includes reset during a draw; no req_done is issued for the in-flight object.
- State S_IDLE:
  - If any req_start is set, select the first set bit scanning from rr_ptr upward, modulo NUM_REQ.
  - Register the selection into grant_id and go to S_DRAW.
  - draw_start=0 in this state.
- State S_DRAW:
  - draw_start=1.
  - draw_type/x/y are muxed combinationally from the req_* slice at grant_id.
  - If draw_done=1: req_done[grant_id]=1 in the same cycle (combinational), rr_ptr<=grant_id+1 (wraps to 0 past NUM_REQ-1), go to S_RELEASE.
  - Else if req_start[grant_id]=0 (requester abort): no req_done, rr_ptr<=grant_id+1, go to S_RELEASE.
  - draw_done takes priority when it coincides with the start deassert.
- State S_RELEASE:
  - Exactly one cycle with draw_start=0, so the engine sees a low gap between consecutive objects.
  - Then go to S_IDLE.
- Latency:
  - A request seen in S_IDLE at cycle t gives draw_start=1 at t+1.
  - After draw_done at cycle d, the next grant can drive draw_start at d+3 (RELEASE at d+1, IDLE at d+2).
- Outputs:
  - draw_type/x/y = 0 when not in S_DRAW.
  - req_done is never asserted outside S_DRAW.
  - req_done is never asserted to a non-granted requester.
- Any draw_done arriving outside S_DRAW is ignored.
- Fairness: with N requesters continuously requesting, each is granted once per N grants.
- A requester that reasserts in the cycle after its done competes normally and is last in round-robin order.
- An unused requester must tie req_start to 0.

Decomposition:
- Shared package draw_pkg: TYPE_W, X_W and Y_W constants, plus localparam state encodings S_IDLE=2'd0, S_DRAW=2'd1, S_RELEASE=2'd2.
- Sub-module rr_select: combinational round-robin pick. Inputs are the req vector and rr_ptr; outputs are valid and idx.
- The FSM, packing muxes and done routing stay in the top module.

Test Plan:
- Single request: req_start=4'b0010, req_type[1]=5'd31, x=98, y=97. Required: draw_start=1 one cycle later with draw_type=31, draw_x=98, draw_y=97. A draw_done pulse then gives req_done=4'b0010 for one cycle, followed by draw_start=0 for ≥2 cycles.
- Contention: req_start=4'b1111 held, engine returns draw_done 5 cycles after each start. Required: grant order 0,1,2,3,0; every req_done one-hot; draw_start low exactly 2 cycles between objects.
- Pointer wrap: last grant=3 and req_start=4'b1001. Required: next grant=0, then 3.
- Abort: requester 2 granted; drop req_start[2] before draw_done. Required: no req_done; S_RELEASE then S_IDLE; rr_ptr=3; a stray draw_done in S_RELEASE produces no req_done.
- Simultaneous: draw_done and req_start[g] falling in the same cycle. Required: req_done[g]=1.
- Reset mid-draw: assert reset while draw_start=1. Required: next cycle all outputs 0, grant_id=0. After reset, req_start=4'b1010 grants requester 1 first.
